// File: rtl/dual_issue_if_id_buffer.sv
// Dual-way IF/ID issue buffer for a 2-wide in-order pipeline.
// Holds one instruction slot per way and an age bit. Each cycle it issues
// in program order, refills freed slots from fetch, and reports to fetch
// how many instructions were consumed.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   IF_valid, IF_pc,
//   IF_inst_0, IF_inst_1        fetch pair (inst_1 sits at IF_pc + PC_STEP)
//   hazard_detected_0/1         per-way issue block from the hazard unit
//   Flush_0, Flush_1            either one empties both ways
//   PCWrite                     0 blocks all refill
//   ID_inst_0/1, ID_pc_0/1,
//   ID_valid_0/1                slot contents presented to ID
//   issue_0/1                   way moves to ID/EX this cycle (comb)
//   Way_0_oldest_ID             1 = way 0 holds the older instruction
//   Way_0_busy                  way 0 was held last cycle and is still occupied
//   fetch_adv                   instructions taken from fetch this cycle (comb)
module dual_issue_if_id_buffer #(
  parameter logic [31:0] NOP_INST = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IF_valid,
  input  logic [31:0] IF_pc,
  input  logic [31:0] IF_inst_0,
  input  logic [31:0] IF_inst_1,
  input  logic        hazard_detected_0,
  input  logic        hazard_detected_1,
  input  logic        Flush_0,
  input  logic        Flush_1,
  input  logic        PCWrite,
  output logic [31:0] ID_inst_0,
  output logic [31:0] ID_inst_1,
  output logic [31:0] ID_pc_0,
  output logic [31:0] ID_pc_1,
  output logic        ID_valid_0,
  output logic        ID_valid_1,
  output logic        issue_0,
  output logic        issue_1,
  output logic        Way_0_oldest_ID,
  output logic        Way_0_busy,
  output logic [1:0]  fetch_adv
);

  logic [31:0] inst0_q, inst0_d, inst1_q, inst1_d;
  logic [31:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic        valid0_q, valid0_d, valid1_q, valid1_d;
  logic        oldest_q, oldest_d;
  logic        busy_q, busy_d;

  logic        flush;
  logic        iss0, iss1;
  logic        free0, free1;
  logic        refill_ok;
  logic [1:0]  adv;

  always_comb begin
    flush = Flush_0 | Flush_1;

    // The younger way may only issue alongside (or without) the older one.
    if (oldest_q) begin
      iss0 = valid0_q & ~hazard_detected_0;
      iss1 = valid1_q & ~hazard_detected_1 & (iss0 | ~valid0_q);
    end else begin
      iss1 = valid1_q & ~hazard_detected_1;
      iss0 = valid0_q & ~hazard_detected_0 & (iss1 | ~valid1_q);
    end
    if (reset || flush) begin
      iss0 = 1'b0;
      iss1 = 1'b0;
    end

    free0     = ~valid0_q | iss0;
    free1     = ~valid1_q | iss1;
    refill_ok = IF_valid & PCWrite & ~flush & ~reset;

    // Baseline: issuing slots drain, held slots keep their contents.
    valid0_d = valid0_q & ~iss0;
    valid1_d = valid1_q & ~iss1;
    inst0_d  = iss0 ? NOP_INST : inst0_q;
    inst1_d  = iss1 ? NOP_INST : inst1_q;
    pc0_d    = iss0 ? '0 : pc0_q;
    pc1_d    = iss1 ? '0 : pc1_q;
    if (valid0_d && !valid1_d)      oldest_d = 1'b1;
    else if (!valid0_d && valid1_d) oldest_d = 1'b0;
    else                            oldest_d = oldest_q;
    adv = 2'd0;

    if (refill_ok) begin
      if (free0 && free1) begin
        inst0_d  = IF_inst_0;
        pc0_d    = IF_pc;
        valid0_d = 1'b1;
        inst1_d  = IF_inst_1;
        pc1_d    = IF_pc + PC_STEP;
        valid1_d = 1'b1;
        oldest_d = 1'b1;
        adv      = 2'd2;
      end else if (free0) begin
        // Way 1 is held and therefore older than the new arrival.
        inst0_d  = IF_inst_0;
        pc0_d    = IF_pc;
        valid0_d = 1'b1;
        oldest_d = 1'b0;
        adv      = 2'd1;
      end else if (free1) begin
        inst1_d  = IF_inst_0;
        pc1_d    = IF_pc;
        valid1_d = 1'b1;
        oldest_d = 1'b1;
        adv      = 2'd1;
      end
    end

    busy_d = valid0_q & ~iss0 & ~flush;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      inst0_q  <= NOP_INST;
      inst1_q  <= NOP_INST;
      pc0_q    <= '0;
      pc1_q    <= '0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      oldest_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      inst0_q  <= inst0_d;
      inst1_q  <= inst1_d;
      pc0_q    <= pc0_d;
      pc1_q    <= pc1_d;
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      oldest_q <= oldest_d;
      busy_q   <= busy_d;
    end
  end

  assign ID_inst_0       = inst0_q;
  assign ID_inst_1       = inst1_q;
  assign ID_pc_0         = pc0_q;
  assign ID_pc_1         = pc1_q;
  assign ID_valid_0      = valid0_q;
  assign ID_valid_1      = valid1_q;
  assign issue_0         = iss0;
  assign issue_1         = iss1;
  assign Way_0_oldest_ID = oldest_q;
  assign Way_0_busy      = busy_q;
  assign fetch_adv       = adv;

endmodule

// File: tb/tb_dual_issue_if_id_buffer.sv
// Self-checking bench for dual_issue_if_id_buffer: directed steps followed by
// random traffic, compared against an age-ordered queue model of the buffer.
module tb_dual_issue_if_id_buffer;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] STEP = 32'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        IF_valid = 1'b0;
  logic [31:0] IF_pc = '0;
  logic [31:0] IF_inst_0 = '0;
  logic [31:0] IF_inst_1 = '0;
  logic        hazard_detected_0 = 1'b0;
  logic        hazard_detected_1 = 1'b0;
  logic        Flush_0 = 1'b0;
  logic        Flush_1 = 1'b0;
  logic        PCWrite = 1'b0;
  logic [31:0] ID_inst_0, ID_inst_1, ID_pc_0, ID_pc_1;
  logic        ID_valid_0, ID_valid_1, issue_0, issue_1;
  logic        Way_0_oldest_ID, Way_0_busy;
  logic [1:0]  fetch_adv;

  dual_issue_if_id_buffer #(.NOP_INST(NOP), .PC_STEP(STEP)) dut (
    .clk(clk), .reset(reset), .IF_valid(IF_valid), .IF_pc(IF_pc),
    .IF_inst_0(IF_inst_0), .IF_inst_1(IF_inst_1),
    .hazard_detected_0(hazard_detected_0), .hazard_detected_1(hazard_detected_1),
    .Flush_0(Flush_0), .Flush_1(Flush_1), .PCWrite(PCWrite),
    .ID_inst_0(ID_inst_0), .ID_inst_1(ID_inst_1),
    .ID_pc_0(ID_pc_0), .ID_pc_1(ID_pc_1),
    .ID_valid_0(ID_valid_0), .ID_valid_1(ID_valid_1),
    .issue_0(issue_0), .issue_1(issue_1),
    .Way_0_oldest_ID(Way_0_oldest_ID), .Way_0_busy(Way_0_busy),
    .fetch_adv(fetch_adv)
  );

  always #5 clk = ~clk;

  int unsigned total  = 0;
  int unsigned passed = 0;

  // Model: occupied ways listed oldest first, plus per-way contents.
  int unsigned age[$];
  logic [31:0] m_inst [2];
  logic [31:0] m_pc   [2];
  logic        m_old  = 1'b1;
  logic        m_busy = 1'b0;

  function automatic bit occupied(input int unsigned w);
    for (int k = 0; k < age.size(); k++) if (age[k] == w) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic step(input bit rst, input bit ifv, input bit pcw,
                      input bit h0, input bit h1, input bit f0, input bit f1,
                      input logic [31:0] pc, input logic [31:0] i0, input logic [31:0] i1);
    bit          hz [2];
    bit          iss [2];
    bit          fl, clr;
    int unsigned rem[$];
    int unsigned adv;
    int unsigned fw;
    logic        busy_next;

    reset = rst; IF_valid = ifv; PCWrite = pcw;
    hazard_detected_0 = h0; hazard_detected_1 = h1;
    Flush_0 = f0; Flush_1 = f1;
    IF_pc = pc; IF_inst_0 = i0; IF_inst_1 = i1;
    #1;

    hz[0] = h0; hz[1] = h1;
    iss[0] = 1'b0; iss[1] = 1'b0;
    fl  = f0 | f1;
    clr = rst | fl;
    adv = 0;
    if (!clr) begin
      // Issue in age order, stopping at the first blocked instruction.
      for (int k = 0; k < age.size(); k++) begin
        if (hz[age[k]]) break;
        iss[age[k]] = 1'b1;
      end
    end
    for (int k = 0; k < age.size(); k++) if (!iss[age[k]]) rem.push_back(age[k]);
    if (ifv && pcw && !clr) adv = 2 - rem.size();

    chk("issue_0", issue_0, iss[0]);
    chk("issue_1", issue_1, iss[1]);
    chk("fetch_adv", fetch_adv, adv);

    busy_next = occupied(0) & ~iss[0] & ~clr;
    @(posedge clk);

    if (clr) begin
      age.delete();
      m_inst[0] = NOP; m_inst[1] = NOP;
      m_pc[0] = '0; m_pc[1] = '0;
      m_old = 1'b1;
      m_busy = 1'b0;
    end else begin
      for (int w = 0; w < 2; w++) if (iss[w]) m_inst[w] = NOP;
      age = rem;
      if (adv == 2) begin
        age.delete();
        age.push_back(0); age.push_back(1);
        m_inst[0] = i0; m_pc[0] = pc;
        m_inst[1] = i1; m_pc[1] = pc + STEP;
      end else if (adv == 1) begin
        fw = occupied(0) ? 1 : 0;
        m_inst[fw] = i0; m_pc[fw] = pc;
        age.push_back(fw);
      end
      if (age.size() > 0) m_old = (age[0] == 0);
      m_busy = busy_next;
    end
    #1;

    chk("ID_valid_0", ID_valid_0, occupied(0));
    chk("ID_valid_1", ID_valid_1, occupied(1));
    chk("ID_inst_0", ID_inst_0, m_inst[0]);
    chk("ID_inst_1", ID_inst_1, m_inst[1]);
    if (occupied(0) || clr) chk("ID_pc_0", ID_pc_0, m_pc[0]);
    if (occupied(1) || clr) chk("ID_pc_1", ID_pc_1, m_pc[1]);
    chk("Way_0_oldest_ID", Way_0_oldest_ID, m_old);
    chk("Way_0_busy", Way_0_busy, m_busy);
  endtask

  initial begin
    m_inst[0] = NOP; m_inst[1] = NOP;
    m_pc[0] = '0; m_pc[1] = '0;

    // Reset held two cycles while fetch offers a pair.
    step(1, 1, 1, 0, 0, 0, 0, 32'h0000_0040, 32'hAAAA_0001, 32'hAAAA_0002);
    step(1, 1, 1, 0, 0, 0, 0, 32'h0000_0040, 32'hAAAA_0001, 32'hAAAA_0002);
    // Fill an empty buffer from 0x100.
    step(0, 1, 1, 0, 0, 0, 0, 32'h0000_0100, 32'h1111_0001, 32'h1111_0002);
    chk("plan_pc0", ID_pc_0, 32'h0000_0100);
    chk("plan_pc1", ID_pc_1, 32'h0000_0104);
    // Older way blocked: younger must not pass it.
    step(0, 1, 1, 1, 0, 0, 0, 32'h0000_0140, 32'h2222_0001, 32'h2222_0002);
    chk("plan_busy", Way_0_busy, 1'b1);
    // Only way 1 blocked: way 0 issues and refills as the younger entry.
    step(0, 1, 1, 0, 1, 0, 0, 32'h0000_0200, 32'h3333_0001, 32'h3333_0002);
    chk("plan_way0_pc", ID_pc_0, 32'h0000_0200);
    chk("plan_oldest", Way_0_oldest_ID, 1'b0);
    // Refill blocked by PCWrite while way 1 stays held.
    step(0, 1, 0, 0, 1, 0, 0, 32'h0000_0300, 32'h4444_0001, 32'h4444_0002);
    // Flush with fetch valid.
    step(0, 1, 1, 0, 0, 0, 1, 32'h0000_0400, 32'h5555_0001, 32'h5555_0002);
    chk("plan_flush_inst0", ID_inst_0, NOP);
    // PC wrap on the second way.
    step(0, 1, 1, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'h6666_0001, 32'h6666_0002);
    chk("plan_pc_wrap", ID_pc_1, 32'h0000_0000);
    // Hazard on an empty way is ignored; both issue, nothing to refill.
    step(0, 0, 1, 0, 0, 0, 0, 32'h0000_0500, 32'h7777_0001, 32'h7777_0002);
    step(0, 1, 1, 1, 1, 0, 0, 32'h0000_0600, 32'h8888_0001, 32'h8888_0002);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      step($urandom_range(0, 63) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 4) != 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 19) == 0,
           rpc, $urandom, $urandom);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
